boot_load_ctrl: RTL and testbench
=================================

Name: boot_load_ctrl

Overview:
Sequencer that brings up the single-cycle rv32i core without testbench-driven memory pokes. It accepts a word stream (header, data image, program image) over a valid/ready interface and writes the data and instruction BRAMs through their write ports. It then releases the core (PC, instruction fetch, register-file read) for a bounded or halt-terminated run and re-stalls it on completion. It owns the select that hands the data-BRAM write port to the core after loading.

Parameters:
ADDR_WIDTH, 10, BRAM byte-address width (word-aligned, addr = index*4)
DATA_WIDTH, 32, stream and BRAM word width
MAX_WORDS, 256, max words per image (2^ADDR_WIDTH/4)
CNT_WIDTH, 16, run-cycle budget and counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin load sequence; honoured only in IDLE, DONE, ERR
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid&s_ready
s_data  in  DATA_WIDTH  stream word
run_cycles  in  CNT_WIDTH  cycle budget; 0 = unbounded (halt only)
halt  in  1  end RUN early
i_w_addr  out  ADDR_WIDTH  instruction BRAM write address
i_w_dat  out  DATA_WIDTH  instruction BRAM write data
i_w_enb  out  1  instruction BRAM write enable
d_w_addr  out  ADDR_WIDTH  data BRAM write address
d_w_dat  out  DATA_WIDTH  data BRAM write data
d_w_enb  out  1  data BRAM write enable
d_bram_init_done  out  1  1 = core owns data BRAM write port
pc_stall  out  1  PC stall
i_r_enb  out  1  instruction BRAM read enable
rd_enbl  out  1  register-file read enable
busy  out  1  high in HDR, LOAD_D, LOAD_I, RUN
done  out  1  high in DONE
error  out  1  high in ERR
cycle_count  out  CNT_WIDTH  RUN cycles elapsed (holds after RUN)

Behaviour:
- Single clock domain. All outputs registered. Reset is synchronous and active-high.
- Reset values: state IDLE; pc_stall=1; everything else 0, including all addresses, data, counters and d_bram_init_done.
- States: IDLE, HDR, LOAD_D, LOAD_I, RUN, DONE, ERR.
- IDLE/DONE/ERR -> HDR on start. start is ignored in every other state.
- Entering HDR clears cycle_count, done and error. d_bram_init_done drops to 0.
- s_ready=1 only in HDR, LOAD_D and LOAD_I. s_data is ignored when s_valid=0. Gaps in s_valid stall progress indefinitely.
- Header word format: [8:0]=n_instr, [24:16]=n_data; all other bits are reserved and must be 0.
- Invalid header: n_instr>MAX_WORDS, n_data>MAX_WORDS, n_instr=0, or nonzero reserved bits.
  - Next state is ERR. ERR is sticky until start or rst.
- Valid header:
  - n_data>0 -> LOAD_D.
  - n_data=0 -> LOAD_I.
- LOAD_D:
  - The k-th accepted word (k from 0) produces a one-cycle d_w_enb pulse on the following cycle, with d_w_addr=k*4 and d_w_dat=word.
  - After word n_data-1 -> LOAD_I.
- LOAD_I: same rule on the i_w_* outputs, with addresses 0,4,..,(n_instr-1)*4.
  - After word n_instr-1 -> RUN.
- Write latency is one cycle from accept to enable. Back-to-back accepts produce back-to-back enables. The last write of each phase still issues after the state changes.
- d_bram_init_done=0 whenever d_w_enb=1. It rises on RUN entry, which is no earlier than the cycle after the last d_w_enb.
- RUN:
  - pc_stall=0, i_r_enb=1, rd_enbl=1, d_bram_init_done=1.
  - run_cycles is sampled on RUN entry.
  - cycle_count increments every RUN cycle.
  - Exit to DONE after exactly run_cycles RUN cycles (run_cycles>0), or on the cycle halt is sampled high. halt wins if both occur.
- DONE: pc_stall=1, i_r_enb=0, rd_enbl=0, d_bram_init_done stays 1 (debug readout path), done=1.
- rst in any state, including mid-load or mid-RUN, returns to reset values on that edge. Words already written to the BRAMs are untouched. A pending write pulse is suppressed.
- Address arithmetic: word index counter is 9 bits; address = {index,2'b00} truncated to ADDR_WIDTH. MAX_WORDS=256 yields final address 0x3FC with no wrap.

Test Plan:
1. Header 0x0002_0005, data {1,2}, 5 instr words, run_cycles=5 -> d_w_enb pulses at addr 0x0,0x4; i_w_enb pulses at 0x0..0x10; pc_stall low exactly 5 cycles; done=1; cycle_count=5; core add program gives x20=3 and mem[0xC]=3.
2. Same stream with s_valid toggled 1-0-0-1 -> identical BRAM contents and addresses; s_ready never drops in load states; write pulses only on accepts.
3. Header 0x0000_0003 (n_data=0) -> no d_w_enb pulse; LOAD_I entered the cycle after header; 3 instr writes; RUN.
4. Headers 0x0000_0000, 0x0101_0001 and 0x8000_0001 -> ERR, error=1, s_ready=0, no write pulses; start then a valid stream -> normal completion with error cleared.
5. rst asserted after 1 of 2 data words -> next cycle state IDLE, pc_stall=1, d_w_enb=0, s_ready=0; restart reloads fully.
6. run_cycles=0 with halt pulsed on RUN cycle 7 -> cycle_count=7 in DONE; pc_stall=1; a start in DONE restarts at HDR.

Source files
------------

// File: rtl/boot_load_ctrl.sv
// Boot loader for the single-cycle rv32i core: streams a header, data image and program image
// into the BRAM write ports, then releases the core for a bounded or halt-terminated run.
module boot_load_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [CNT_WIDTH-1:0]  run_cycles,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  d_bram_init_done,
    output logic                  pc_stall,
    output logic                  i_r_enb,
    output logic                  rd_enbl,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam int IDX_W = 9;
    localparam logic [IDX_W:0] MAX_W = (IDX_W + 1)'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD_D,
        S_LOAD_I,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      n_data_q, n_data_d;
    logic [IDX_W-1:0]      n_instr_q, n_instr_d;
    logic [CNT_WIDTH-1:0]  budget_q, budget_d;
    logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
    logic [ADDR_WIDTH-1:0] i_w_addr_q, i_w_addr_d;
    logic [DATA_WIDTH-1:0] i_w_dat_q, i_w_dat_d;
    logic                  i_w_enb_q, i_w_enb_d;
    logic [ADDR_WIDTH-1:0] d_w_addr_q, d_w_addr_d;
    logic [DATA_WIDTH-1:0] d_w_dat_q, d_w_dat_d;
    logic                  d_w_enb_q, d_w_enb_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  pc_stall_q, pc_stall_d;
    logic                  i_r_enb_q, i_r_enb_d;
    logic                  rd_enbl_q, rd_enbl_d;
    logic                  d_init_q, d_init_d;

    // Header decode: every bit outside the two count fields is reserved.
    logic [DATA_WIDTH-1:0] rsvd_mask;
    logic [IDX_W-1:0]      hdr_n_instr;
    logic [IDX_W-1:0]      hdr_n_data;
    logic                  hdr_bad;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] idx_addr;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_rsvd
            assign rsvd_mask[gi] = !((gi <= 8) || ((gi >= 16) && (gi <= 24)));
        end
    endgenerate

    assign hdr_n_instr = s_data[8:0];
    assign hdr_n_data  = s_data[24:16];
    assign hdr_bad     = (hdr_n_instr == '0)
                      || ({1'b0, hdr_n_instr} > MAX_W)
                      || ({1'b0, hdr_n_data} > MAX_W)
                      || (|(s_data & rsvd_mask));
    assign accept      = s_valid && s_ready_q;
    assign idx_addr    = ADDR_WIDTH'({idx_q, 2'b00});

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        n_data_d      = n_data_q;
        n_instr_d     = n_instr_q;
        budget_d      = budget_q;
        cycle_count_d = cycle_count_q;
        i_w_addr_d    = i_w_addr_q;
        i_w_dat_d     = i_w_dat_q;
        i_w_enb_d     = 1'b0;
        d_w_addr_d    = d_w_addr_q;
        d_w_dat_d     = d_w_dat_q;
        d_w_enb_d     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d       = S_HDR;
                    cycle_count_d = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (hdr_bad) begin
                        state_d = S_ERR;
                    end else begin
                        n_data_d  = hdr_n_data;
                        n_instr_d = hdr_n_instr;
                        idx_d     = '0;
                        state_d   = (hdr_n_data != '0) ? S_LOAD_D : S_LOAD_I;
                    end
                end
            end
            S_LOAD_D: begin
                if (accept) begin
                    d_w_enb_d  = 1'b1;
                    d_w_addr_d = idx_addr;
                    d_w_dat_d  = s_data;
                    if (idx_q == n_data_q - 9'd1) begin
                        idx_d   = '0;
                        state_d = S_LOAD_I;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            S_LOAD_I: begin
                if (accept) begin
                    i_w_enb_d  = 1'b1;
                    i_w_addr_d = idx_addr;
                    i_w_dat_d  = s_data;
                    if (idx_q == n_instr_q - 9'd1) begin
                        idx_d    = '0;
                        budget_d = run_cycles;
                        state_d  = S_RUN;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            S_RUN: begin
                cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
                // A zero budget means only halt can end the run.
                if (halt || ((budget_q != '0) && (cycle_count_d == budget_q))) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        s_ready_d  = (state_d == S_HDR) || (state_d == S_LOAD_D) || (state_d == S_LOAD_I);
        busy_d     = s_ready_d || (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        pc_stall_d = (state_d != S_RUN);
        i_r_enb_d  = (state_d == S_RUN);
        rd_enbl_d  = (state_d == S_RUN);
        // Core keeps the data write port through DONE so results can be read back.
        d_init_d   = (state_d == S_RUN) || (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            n_data_q      <= '0;
            n_instr_q     <= '0;
            budget_q      <= '0;
            cycle_count_q <= '0;
            i_w_addr_q    <= '0;
            i_w_dat_q     <= '0;
            i_w_enb_q     <= 1'b0;
            d_w_addr_q    <= '0;
            d_w_dat_q     <= '0;
            d_w_enb_q     <= 1'b0;
            s_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            pc_stall_q    <= 1'b1;
            i_r_enb_q     <= 1'b0;
            rd_enbl_q     <= 1'b0;
            d_init_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            n_data_q      <= n_data_d;
            n_instr_q     <= n_instr_d;
            budget_q      <= budget_d;
            cycle_count_q <= cycle_count_d;
            i_w_addr_q    <= i_w_addr_d;
            i_w_dat_q     <= i_w_dat_d;
            i_w_enb_q     <= i_w_enb_d;
            d_w_addr_q    <= d_w_addr_d;
            d_w_dat_q     <= d_w_dat_d;
            d_w_enb_q     <= d_w_enb_d;
            s_ready_q     <= s_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            pc_stall_q    <= pc_stall_d;
            i_r_enb_q     <= i_r_enb_d;
            rd_enbl_q     <= rd_enbl_d;
            d_init_q      <= d_init_d;
        end
    end

    assign s_ready          = s_ready_q;
    assign i_w_addr         = i_w_addr_q;
    assign i_w_dat          = i_w_dat_q;
    assign i_w_enb          = i_w_enb_q;
    assign d_w_addr         = d_w_addr_q;
    assign d_w_dat          = d_w_dat_q;
    assign d_w_enb          = d_w_enb_q;
    assign d_bram_init_done = d_init_q;
    assign pc_stall         = pc_stall_q;
    assign i_r_enb          = i_r_enb_q;
    assign rd_enbl          = rd_enbl_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign cycle_count      = cycle_count_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Scoreboard bench for boot_load_ctrl: stimulus queues expected BRAM writes, a negedge
// monitor pops and compares them as the write enables appear.
module tb_boot_load_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [CW-1:0] run_cycles;
    logic          halt;
    logic [AW-1:0] i_w_addr;
    logic [DW-1:0] i_w_dat;
    logic          i_w_enb;
    logic [AW-1:0] d_w_addr;
    logic [DW-1:0] d_w_dat;
    logic          d_w_enb;
    logic          d_bram_init_done;
    logic          pc_stall;
    logic          i_r_enb;
    logic          rd_enbl;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] cycle_count;

    boot_load_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_WORDS (256),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .run_cycles      (run_cycles),
        .halt            (halt),
        .i_w_addr        (i_w_addr),
        .i_w_dat         (i_w_dat),
        .i_w_enb         (i_w_enb),
        .d_w_addr        (d_w_addr),
        .d_w_dat         (d_w_dat),
        .d_w_enb         (d_w_enb),
        .d_bram_init_done(d_bram_init_done),
        .pc_stall        (pc_stall),
        .i_r_enb         (i_r_enb),
        .rd_enbl         (rd_enbl),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .cycle_count     (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } wr_t;

    wr_t           exp_d[$];
    wr_t           exp_i[$];
    wr_t           mon_e;
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] d_img [0:255];
    logic [DW-1:0] i_img [0:255];
    int            run_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (d_w_enb === 1'b1) begin
            check("d_init_low_during_dwrite", {31'd0, d_bram_init_done}, 32'd0);
            if (exp_d.size() == 0) begin
                check("d_w_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_d.pop_front();
                check("d_w_addr", {22'd0, d_w_addr}, {22'd0, mon_e.addr});
                check("d_w_dat", d_w_dat, mon_e.dat);
                $display("d write addr=0x%03h dat=0x%08h", d_w_addr, d_w_dat);
            end
        end
        if (i_w_enb === 1'b1) begin
            if (exp_i.size() == 0) begin
                check("i_w_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_i.pop_front();
                check("i_w_addr", {22'd0, i_w_addr}, {22'd0, mon_e.addr});
                check("i_w_dat", i_w_dat, mon_e.dat);
                $display("i write addr=0x%03h dat=0x%08h", i_w_addr, i_w_dat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_d(input int k, input logic [DW-1:0] w);
        wr_t e;
        e.addr = AW'(k * 4);
        e.dat  = w;
        exp_d.push_back(e);
    endtask

    task automatic push_i(input int k, input logic [DW-1:0] w);
        wr_t e;
        e.addr = AW'(k * 4);
        e.dat  = w;
        exp_i.push_back(e);
    endtask

    // Optional idle gap (s_valid low) before the word; s_ready must stay up during it.
    task automatic send(input logic [DW-1:0] w, input int gap);
        logic acc;
        int   n;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_data  = 32'hDEAD_BEEF;
            check("s_ready_in_gap", {31'd0, s_ready}, 32'd1);
            tick();
        end
        s_valid = 1'b1;
        s_data  = w;
        n       = 0;
        do begin
            acc = s_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic load(input logic [DW-1:0] hdr, input int nd, input int ni, input int gap);
        pulse_start();
        send(hdr, 0);
        for (int k = 0; k < nd; k++) begin
            push_d(k, d_img[k]);
            send(d_img[k], gap);
        end
        for (int k = 0; k < ni; k++) begin
            push_i(k, i_img[k]);
            send(i_img[k], gap);
        end
    endtask

    task automatic wait_done(input int limit, output int rl);
        int n;
        n  = 0;
        rl = 0;
        while (done !== 1'b1 && n < limit) begin
            if (pc_stall === 1'b0) rl++;
            tick();
            n++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic check_done_state(input string tag, input int rl, input int budget);
        $display("%s: run_len=%0d cycle_count=%0d done=%0b", tag, rl, cycle_count, done);
        check({tag, "_run_len"}, rl, budget);
        check({tag, "_cycle_count"}, {16'd0, cycle_count}, budget);
        check({tag, "_pc_stall"}, {31'd0, pc_stall}, 32'd1);
        check({tag, "_i_r_enb"}, {31'd0, i_r_enb}, 32'd0);
        check({tag, "_d_init"}, {31'd0, d_bram_init_done}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_dq_empty"}, exp_d.size(), 32'd0);
        check({tag, "_iq_empty"}, exp_i.size(), 32'd0);
    endtask

    logic [DW-1:0] bad_hdrs [0:3];

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        run_cycles = '0;
        halt       = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_pc_stall", {31'd0, pc_stall}, 32'd1);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_d_init", {31'd0, d_bram_init_done}, 32'd0);
        check("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
        check("rst_i_r_enb", {31'd0, i_r_enb}, 32'd0);

        // Test 1: two data words, five instructions, budget 5
        d_img[0] = 32'h0000_0001;
        d_img[1] = 32'h0000_0002;
        i_img[0] = 32'h0000_2083;
        i_img[1] = 32'h0040_2103;
        i_img[2] = 32'h0020_8A33;
        i_img[3] = 32'h0140_2623;
        i_img[4] = 32'h0000_006F;
        run_cycles = 16'd5;
        load(32'h0002_0005, 2, 5, 0);
        check("t1_run_entry_d_init", {31'd0, d_bram_init_done}, 32'd1);
        check("t1_run_entry_rd_enbl", {31'd0, rd_enbl}, 32'd1);
        wait_done(50, run_len);
        check_done_state("t1", run_len, 5);

        // Test 2: same stream with two-cycle valid gaps
        load(32'h0002_0005, 2, 5, 2);
        wait_done(50, run_len);
        check_done_state("t2", run_len, 5);

        // Test 3: no data image, straight into instruction load
        run_cycles = 16'd2;
        pulse_start();
        send(32'h0000_0003, 0);
        for (int k = 0; k < 3; k++) begin
            push_i(k, 32'hC0DE_0000 + k);
            send(32'hC0DE_0000 + k, 0);
            if (k == 0) check("t3_first_iw_next_cycle", {31'd0, i_w_enb}, 32'd1);
        end
        wait_done(50, run_len);
        check_done_state("t3", run_len, 2);

        // Test 4: malformed headers end in sticky ERR
        bad_hdrs[0] = 32'h0000_0000;
        bad_hdrs[1] = 32'h0101_0001;
        bad_hdrs[2] = 32'h8000_0001;
        bad_hdrs[3] = 32'h0000_0101;
        for (int h = 0; h < 4; h++) begin
            pulse_start();
            send(bad_hdrs[h], 0);
            $display("bad header 0x%08h: error=%0b s_ready=%0b", bad_hdrs[h], error, s_ready);
            check("t4_error", {31'd0, error}, 32'd1);
            check("t4_s_ready", {31'd0, s_ready}, 32'd0);
            check("t4_busy", {31'd0, busy}, 32'd0);
            s_valid = 1'b1;
            s_data  = 32'h0001_0001;
            tick();
            tick();
            s_valid = 1'b0;
            check("t4_err_sticky", {31'd0, error}, 32'd1);
        end
        d_img[0]   = 32'hA5A5_5A5A;
        i_img[0]   = 32'h0000_0013;
        run_cycles = 16'd3;
        load(32'h0001_0001, 1, 1, 0);
        wait_done(50, run_len);
        check_done_state("t4", run_len, 3);

        // Test 5: reset in the middle of the data image
        pulse_start();
        send(32'h0002_0002, 0);
        push_d(0, 32'h1111_1111);
        send(32'h1111_1111, 0);
        rst = 1'b1;
        tick();
        check("t5_pc_stall", {31'd0, pc_stall}, 32'd1);
        check("t5_d_w_enb", {31'd0, d_w_enb}, 32'd0);
        check("t5_s_ready", {31'd0, s_ready}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_cycle_count", {16'd0, cycle_count}, 32'd0);
        rst = 1'b0;
        tick();
        d_img[0]   = 32'h2222_2222;
        d_img[1]   = 32'h3333_3333;
        i_img[0]   = 32'h4444_4444;
        i_img[1]   = 32'h5555_5555;
        run_cycles = 16'd4;
        load(32'h0002_0002, 2, 2, 0);
        wait_done(50, run_len);
        check_done_state("t5", run_len, 4);

        // Test 6: unbounded run ended by halt on RUN cycle 7
        run_cycles = 16'd0;
        load(32'h0000_0002, 0, 2, 0);
        for (int c = 1; c < 7; c++) tick();
        check("t6_still_running", {31'd0, pc_stall}, 32'd0);
        check("t6_not_done", {31'd0, done}, 32'd0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        $display("halt run: cycle_count=%0d done=%0b", cycle_count, done);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_cycle_count", {16'd0, cycle_count}, 32'd7);
        check("t6_pc_stall", {31'd0, pc_stall}, 32'd1);
        pulse_start();
        check("t6_restart_busy", {31'd0, busy}, 32'd1);
        check("t6_restart_s_ready", {31'd0, s_ready}, 32'd1);
        check("t6_restart_done", {31'd0, done}, 32'd0);
        check("t6_restart_d_init", {31'd0, d_bram_init_done}, 32'd0);
        check("t6_restart_cycle_count", {16'd0, cycle_count}, 32'd0);

        // Test 7: already in HDR; full 256-word program reaches 0x3FC
        run_cycles = 16'd1;
        send(32'h0000_0100, 0);
        for (int k = 0; k < 256; k++) begin
            push_i(k, 32'h1000_0000 + k);
            send(32'h1000_0000 + k, 0);
        end
        check("t7_last_i_addr", {22'd0, i_w_addr}, 32'h0000_03FC);
        wait_done(50, run_len);
        check_done_state("t7", run_len, 1);

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
